// File: rtl/alarm_clock_pkg.sv
// Shared encodings and default timing for the clock's time-setting input path.
// Field and state codes are common to the setting controller and the timekeeping core.
package alarm_clock_pkg;

  localparam logic [1:0] FIELD_HOURS = 2'd0;
  localparam logic [1:0] FIELD_MIN   = 2'd1;
  localparam logic [1:0] FIELD_SEC   = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SET  = 1'b1
  } state_t;

  // Default timing at 50 MHz: 20 ms debounce, 0.5 s repeat delay, 0.1 s repeat, 2 Hz blink
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_RATE     = 5_000_000;
  localparam int DEF_BLINK_HALF      = 12_500_000;
  localparam int DEF_CNT_W           = 25;

  function automatic logic [1:0] next_field(input logic [1:0] f);
    case (f)
      FIELD_HOURS: next_field = FIELD_MIN;
      FIELD_MIN:   next_field = FIELD_SEC;
      default:     next_field = FIELD_HOURS;
    endcase
  endfunction

endpackage

// File: rtl/time_set_input_ctrl_if.sv
// Board-side raw inputs and the clean setting commands handed to the timekeeping core.
interface time_set_input_ctrl_if;
  logic       set_clock;
  logic       push2;
  logic       push3;
  logic       setting;
  logic [1:0] field_sel;
  logic       inc_pulse;
  logic       blink;

  modport master (
    output set_clock, push2, push3,
    input  setting, field_sel, inc_pulse, blink
  );

  modport slave (
    input  set_clock, push2, push3,
    output setting, field_sel, inc_pulse, blink
  );
endinterface

// File: rtl/key_debounce.sv
// Debounces one synchronised active-low key and strobes press on a stable 1->0 edge.
// The stable level starts released, so a key held through reset must be re-qualified.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 25
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic key_sync,
  output logic key_stable,
  output logic press
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      key_stable <= 1'b1;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == key_stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        key_stable <= key_sync;
        cnt_q      <= '0;
        press      <= key_stable & ~key_sync;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_input_ctrl.sv
// Turns the set_clock switch and push2/push3 keys into field select, increment
// pulses with hold-to-repeat, and a blink enable for the field being set.
module time_set_input_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,   // must be >= 2
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,    // must be >= 2
  parameter int BLINK_HALF      = DEF_BLINK_HALF,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                       clk50,
  input  logic                       rst_n,
  time_set_input_ctrl_if.slave       bus
);

  // {set_clock, push2, push3}; keys reset to released so nothing counts out of reset
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b011;
      sync2_q <= 3'b011;
    end else begin
      sync1_q <= {bus.set_clock, bus.push2, bus.push3};
      sync2_q <= sync1_q;
    end
  end

  logic set_sync;
  logic p2_press, p2_stable_unused;
  logic p3_press, p3_stable;

  assign set_sync = sync2_q[2];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_push2 (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .key_sync   (sync2_q[1]),
    .key_stable (p2_stable_unused),
    .press      (p2_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_push3 (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .key_sync   (sync2_q[0]),
    .key_stable (p3_stable),
    .press      (p3_press)
  );

  state_t           state_q, state_d;
  logic [1:0]       field_q, field_d;
  logic             inc_q, inc_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             armed_q, armed_d;
  logic             rfirst_q, rfirst_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] rpt_lim;

  // First repeat waits the long delay, the rest run at the repeat rate
  assign rpt_lim = rfirst_q ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      field_q  <= FIELD_HOURS;
      inc_q    <= 1'b0;
      blink_q  <= 1'b1;
      bcnt_q   <= '0;
      armed_q  <= 1'b0;
      rfirst_q <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      inc_q    <= inc_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
      armed_q  <= armed_d;
      rfirst_q <= rfirst_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    inc_d    = 1'b0;
    blink_d  = blink_q;
    bcnt_d   = bcnt_q;
    armed_d  = armed_q;
    rfirst_d = rfirst_q;
    rcnt_d   = rcnt_q;
    if (state_q == ST_IDLE || !set_sync) begin
      // Outside SET (or leaving it) everything sits at its entry values
      field_d = FIELD_HOURS;
      blink_d = 1'b1;
      bcnt_d  = '0;
      armed_d = 1'b0;
      rcnt_d  = '0;
      state_d = set_sync ? ST_SET : ST_IDLE;
    end else begin
      if (bcnt_q == CNT_W'(BLINK_HALF - 1)) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + CNT_W'(1);
      end
      if (p2_press || p3_press) begin
        blink_d = 1'b1;
        bcnt_d  = '0;
      end
      // Field advance wins over a same-cycle increment press
      if (p2_press) begin
        field_d = next_field(field_q);
        armed_d = 1'b0;
      end else if (p3_press) begin
        inc_d    = 1'b1;
        armed_d  = 1'b1;
        rfirst_d = 1'b1;
        rcnt_d   = '0;
      end else if (armed_q) begin
        if (p3_stable) begin
          armed_d = 1'b0;
        end else if (rcnt_q == rpt_lim) begin
          inc_d    = 1'b1;
          rfirst_d = 1'b0;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.setting   = (state_q == ST_SET);
  assign bus.field_sel = field_q;
  assign bus.inc_pulse = inc_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_time_set_input_ctrl.sv
// Directed bench for time_set_input_ctrl with shortened timing constants.
module tb_time_set_input_ctrl;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  time_set_input_ctrl_if bus();

  time_set_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_RATE     (5),
    .BLINK_HALF      (8),
    .CNT_W           (25)
  ) dut (
    .clk50 (clk50),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int   pulses[$];
  int   consec = 0;
  logic prev_inc = 1'b0;
  always @(negedge clk50) begin
    if (bus.inc_pulse) pulses.push_back(cyc);
    if (bus.inc_pulse && prev_inc) consec++;
    prev_inc = bus.inc_pulse;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int pulse_at(input int i);
    return (pulses.size() > i) ? pulses[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk50); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic sample_at(input int c);
    wait_until(c);
    @(negedge clk50);
  endtask

  task automatic tap_push2();
    int t0;
    t0 = cyc;
    bus.push2 = 1'b0;
    wait_until(t0 + 8);
    bus.push2 = 1'b1;
    wait_until(t0 + 16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t, p, d, r;
  int rep_off[8] = '{0, 20, 25, 30, 35, 40, 45, 50};
  int field_exp[3] = '{1, 2, 0};

  initial begin
    bus.set_clock = 1'b0;
    bus.push2     = 1'b1;
    bus.push3     = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_setting", bus.setting, 0);
    chk("rst_field", bus.field_sel, 0);
    chk("rst_inc", bus.inc_pulse, 0);
    chk("rst_blink", bus.blink, 1);
    rst_n = 1'b1;
    step();

    // enter SET: two sync flops then one state edge
    t = cyc;
    bus.set_clock = 1'b1;
    sample_at(t + 2);
    chk("set_lat_early", bus.setting, 0);
    sample_at(t + 3);
    chk("set_entered", bus.setting, 1);
    chk("set_field0", bus.field_sel, 0);
    chk("set_blink1", bus.blink, 1);

    // 3-cycle bounce gives nothing
    pulses.delete();
    step();
    t = cyc;
    bus.push3 = 1'b0;
    wait_until(t + 3);
    bus.push3 = 1'b1;
    wait_until(t + 15);
    chk("bounce_no_pulse", pulses.size(), 0);

    // clean press, released before repeat
    t = cyc;
    bus.push3 = 1'b0;
    wait_until(t + 10);
    bus.push3 = 1'b1;
    wait_until(t + 40);
    chk("press_count", pulses.size(), 1);
    chk("press_latency", pulse_at(0), t + 7);

    // hold for auto-repeat
    pulses.delete();
    t = cyc;
    p = t + 7;
    bus.push3 = 1'b0;
    wait_until(p + 46);
    bus.push3 = 1'b1;
    wait_until(p + 70);
    chk("repeat_count", pulses.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("repeat_%0d", i), pulse_at(i), p + rep_off[i]);

    // field advance wraps
    pulses.delete();
    for (int k = 0; k < 3; k++) begin
      tap_push2();
      chk($sformatf("field_adv_%0d", k), bus.field_sel, field_exp[k]);
    end
    chk("field_no_inc", pulses.size(), 0);

    // simultaneous press: advance wins
    t = cyc;
    bus.push2 = 1'b0;
    bus.push3 = 1'b0;
    wait_until(t + 8);
    bus.push2 = 1'b1;
    bus.push3 = 1'b1;
    wait_until(t + 20);
    chk("both_field", bus.field_sel, 1);
    chk("both_no_inc", pulses.size(), 0);

    // press forces blink high and restarts the period
    pulses.delete();
    t = cyc;
    bus.push3 = 1'b0;
    wait_until(t + 6);
    bus.push3 = 1'b1;
    for (int c = t + 7; c < t + 47; c++) begin
      sample_at(c);
      chk($sformatf("blink_c%0d", c - t - 7), bus.blink, (((c - t - 7) / 8) % 2 == 0) ? 1 : 0);
    end
    chk("blink_press_count", pulses.size(), 1);
    chk("blink_press_at", pulse_at(0), t + 7);

    // drop set_clock mid-repeat
    pulses.delete();
    step();
    t = cyc;
    p = t + 7;
    bus.push3 = 1'b0;
    wait_until(p + 22);
    d = cyc;
    bus.set_clock = 1'b0;
    sample_at(d + 2);
    chk("drop_still_set", bus.setting, 1);
    sample_at(d + 3);
    chk("drop_idle", bus.setting, 0);
    chk("drop_field0", bus.field_sel, 0);
    chk("drop_blink1", bus.blink, 1);
    wait_until(d + 30);
    chk("drop_pulse_count", pulses.size(), 2);
    chk("drop_first_rpt", pulse_at(1), p + 20);
    bus.push3 = 1'b1;
    wait_until(cyc + 10);

    // async reset mid-pulse, key still held afterwards
    bus.set_clock = 1'b1;
    wait_until(cyc + 6);
    tap_push2();
    chk("pre_rst_field", bus.field_sel, 1);
    t = cyc;
    p = t + 7;
    bus.push3 = 1'b0;
    sample_at(p);
    chk("pre_rst_inc", bus.inc_pulse, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_setting", bus.setting, 0);
    chk("arst_field", bus.field_sel, 0);
    chk("arst_inc", bus.inc_pulse, 0);
    chk("arst_blink", bus.blink, 1);
    step();
    step();
    pulses.delete();
    r = cyc;
    rst_n = 1'b1;
    wait_until(r + 15);
    chk("held_after_rst_count", pulses.size(), 1);
    chk("held_after_rst_at", pulse_at(0), r + 7);
    bus.push3 = 1'b1;
    wait_until(cyc + 12);

    chk("no_back_to_back", consec, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
